ped_crossing_controller: RTL and testbench
==========================================

// Module: ped_crossing_controller
// PURPOSE
//   Pedestrian signal stage downstream of the traffic light FSM. Consumes the NS lamp code
//   ({red,yellow,green} one-hot: 001 green, 010 yellow, 100 red) and a raw push-button.
//   Drives WALK / DONT_WALK lamps for the crosswalk that runs parallel to NS traffic.
//   Synchronises and debounces the button, latches requests, and grants WALK only at the
//   start of an NS green phase. Forces DONT_WALK whenever NS is not green or the code is illegal.
// PARAMETERS
//   DEBOUNCE_CYCLES  4   consecutive cycles btn must hold a new level before it is accepted (>=1)
//   WALK_CYCLES      8   cycles of solid WALK (>=1)
//   FLASH_CYCLES     6   cycles of flashing DONT_WALK after WALK (>=2, even)
//   CNT_W            5   width of the internal timers and of countdown; must hold max(params)
// PORTS
//   clk          in   1      system clock, all state on rising edge
//   reset        in   1      synchronous, active-high reset
//   NS           in   3      NS lamp code from the traffic light controller
//   btn          in   1      raw asynchronous pedestrian push-button, active-high
//   walk         out  1      WALK lamp
//   dont_walk    out  1      DONT_WALK lamp (toggles while flashing)
//   countdown    out  CNT_W  cycles remaining in FLASH, else 0
//   req_pending  out  1      accepted request waiting for the next NS green
//   abort        out  1      one-cycle pulse: WALK/FLASH cut short by NS leaving green
//   fault        out  1      sticky: illegal NS code seen; cleared only by reset
// BEHAVIOUR
//   Reset (sampled high at edge): walk=0 dont_walk=1 countdown=0 req_pending=0 abort=0 fault=0,
//     state=IDLE, sync/debounce regs=0, ns_prev=100. Reset overrides everything, including mid-WALK.
//   All outputs are registered.
//   Input path: btn -> 2-flop synchroniser (s1,s2).
//     Debounce counter increments while s2 != btn_stable and clears when they are equal.
//     btn_stable takes s2 when the count reaches DEBOUNCE_CYCLES.
//     A 0->1 of btn_stable sets req_pending on the next edge.
//     Net latency: req_pending high after the (DEBOUNCE_CYCLES+3)th edge, counting the first
//     edge that samples btn=1, provided btn is held.
//     Pulses shorter than DEBOUNCE_CYCLES after sync are ignored.
//   green_start = (NS==001) && (ns_prev!=001). ns_prev is NS registered every cycle.
//   Legal codes: 001, 010, 100. Any other code sets fault, forces state IDLE (walk=0,
//     dont_walk=1) and blocks all WALK grants until reset. req_pending still latches.
//   FSM:
//     IDLE : walk=0 dont_walk=1. If req_pending & green_start & !fault -> WALK,
//            load timer=WALK_CYCLES-1. req_pending clears on that edge, unless a new
//            accepted press occurs on the same edge (set wins).
//            A request accepted after green_start waits for the next green; it never joins mid-green.
//     WALK : walk=1 dont_walk=0; timer decrements each cycle.
//            At timer==0 -> FLASH, load timer=FLASH_CYCLES-1.
//     FLASH: walk=0. dont_walk=1 on the first FLASH cycle, then toggles every cycle.
//            countdown=timer+1, counting FLASH_CYCLES down to 1. At timer==0 -> IDLE, countdown=0.
//     In WALK or FLASH, NS!=001 -> IDLE next edge with dont_walk=1, countdown=0, abort=1 for
//       one cycle. An illegal code takes the fault path (abort also pulses).
//   Presses during WALK/FLASH set req_pending for the next green.
//   Timing: WALK+FLASH = 14 cycles fits inside the 16-cycle upstream green, so abort
//     indicates a misconfiguration.
// TESTING (DEBOUNCE=4, WALK=8, FLASH=6)
//   1. reset held 3 cycles mid-WALK -> next cycle walk=0 dont_walk=1 req_pending=0 fault=0 countdown=0.
//   2. btn high 2 cycles then low -> req_pending stays 0.
//      btn held -> req_pending=1 after edge 7 from first sample.
//   3. req_pending=1, NS 100->001 -> walk=1 for exactly 8 cycles from the next edge,
//      then dont_walk pattern 1,0,1,0,1,0 with countdown 6..1, then IDLE, req_pending=0.
//   4. Press during NS green after green_start -> no walk this green.
//      WALK starts on the next 100->001 transition.
//   5. NS forced 001->010 on WALK cycle 3 -> walk=0, dont_walk=1, abort pulse of 1 cycle,
//      state IDLE.
//   6. NS=011 for 1 cycle -> fault=1 sticky. Later green with req_pending=1 grants no walk
//      until reset.

Source files
------------

// File: rtl/ped_crossing_controller.sv
// Pedestrian crossing signal controller.
// Synchronises and debounces a raw push-button, latches requests, and grants
// WALK only at the start of an NS green phase. Solid WALK is followed by a
// flashing DONT_WALK with a countdown. DONT_WALK is forced whenever NS is not
// green. An illegal NS lamp code sets a sticky fault that blocks all grants
// until reset.
//
// Ports:
//   clk          in   system clock, all state on rising edge
//   reset        in   synchronous, active-high reset
//   NS           in   NS lamp code {red,yellow,green}, one-hot
//   btn          in   raw asynchronous push-button, active-high
//   walk         out  WALK lamp
//   dont_walk    out  DONT_WALK lamp (toggles while flashing)
//   countdown    out  cycles remaining in FLASH, else 0
//   req_pending  out  accepted request waiting for the next NS green
//   abort        out  one-cycle pulse: WALK/FLASH cut short by NS leaving green
//   fault        out  sticky illegal-NS-code flag
module ped_crossing_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned WALK_CYCLES     = 8,
    parameter int unsigned FLASH_CYCLES    = 6,
    parameter int unsigned CNT_W           = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       NS,
    input  logic             btn,
    output logic             walk,
    output logic             dont_walk,
    output logic [CNT_W-1:0] countdown,
    output logic             req_pending,
    output logic             abort,
    output logic             fault
);

    typedef enum logic [1:0] {IDLE, WALK, FLASH} state_t;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_CYCLES - 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   timer, timer_next;
    logic [CNT_W-1:0]   deb_cnt;
    logic               s1, s2, btn_stable, stable_d;
    logic [2:0]         ns_prev;
    logic               ns_green, ns_legal, green_start, press, grant;
    logic               walk_next, dont_walk_next, abort_next;
    logic [CNT_W-1:0]   countdown_next;

    assign ns_green    = (NS == 3'b001);
    assign ns_legal    = (NS == 3'b001) || (NS == 3'b010) || (NS == 3'b100);
    assign green_start = ns_green && (ns_prev != 3'b001);
    // Accepted press: rising edge of the debounced level, one cycle after it settles.
    assign press       = btn_stable && !stable_d;

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            btn_stable  <= 1'b0;
            stable_d    <= 1'b0;
            deb_cnt     <= '0;
            ns_prev     <= 3'b100;
            state       <= IDLE;
            timer       <= '0;
            walk        <= 1'b0;
            dont_walk   <= 1'b1;
            countdown   <= '0;
            req_pending <= 1'b0;
            abort       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            s1       <= btn;
            s2       <= s1;
            stable_d <= btn_stable;
            if (s2 != btn_stable) begin
                if (deb_cnt == DEB_LAST) begin
                    btn_stable <= s2;
                    deb_cnt    <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
            ns_prev   <= NS;
            state     <= state_next;
            timer     <= timer_next;
            walk      <= walk_next;
            dont_walk <= dont_walk_next;
            countdown <= countdown_next;
            abort     <= abort_next;
            fault     <= fault | ~ns_legal;
            // A press on the grant edge wins over the clear.
            if (press) begin
                req_pending <= 1'b1;
            end else if (grant) begin
                req_pending <= 1'b0;
            end
        end
    end

    // Next-state and timer logic.
    always_comb begin
        state_next = state;
        timer_next = timer;
        grant      = 1'b0;
        if (!ns_legal) begin
            state_next = IDLE;
            timer_next = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_pending && green_start && !fault) begin
                        state_next = WALK;
                        timer_next = WALK_LAST;
                        grant      = 1'b1;
                    end
                end
                WALK: begin
                    if (!ns_green) begin
                        state_next = IDLE;
                        timer_next = '0;
                    end else if (timer == '0) begin
                        state_next = FLASH;
                        timer_next = FLASH_LAST;
                    end else begin
                        timer_next = timer - 1'b1;
                    end
                end
                FLASH: begin
                    if (!ns_green || timer == '0) begin
                        state_next = IDLE;
                        timer_next = '0;
                    end else begin
                        timer_next = timer - 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    timer_next = '0;
                end
            endcase
        end
    end

    // Output values, decoded from the upcoming state and registered above.
    always_comb begin
        walk_next      = (state_next == WALK);
        dont_walk_next = 1'b1;
        countdown_next = '0;
        abort_next     = (state == WALK || state == FLASH) && !ns_green;
        if (state_next == WALK) begin
            dont_walk_next = 1'b0;
        end else if (state_next == FLASH) begin
            // Lit on FLASH entry, then alternates every cycle.
            dont_walk_next = (state == FLASH) ? ~dont_walk : 1'b1;
            countdown_next = timer_next + 1'b1;
        end
    end

endmodule

// File: tb/tb_ped_crossing_controller.sv
module tb_ped_crossing_controller;

    localparam int unsigned DEB   = 4;
    localparam int unsigned WALKC = 8;
    localparam int unsigned FLSH  = 6;
    localparam int unsigned CW    = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    NS = 3'b100;
    logic          btn = 1'b0;
    logic          walk, dont_walk, req_pending, abort, fault;
    logic [CW-1:0] countdown;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    ped_crossing_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .WALK_CYCLES(WALKC),
        .FLASH_CYCLES(FLSH),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .NS(NS),
        .btn(btn),
        .walk(walk),
        .dont_walk(dont_walk),
        .countdown(countdown),
        .req_pending(req_pending),
        .abort(abort),
        .fault(fault)
    );

    always #5 clk = ~clk;

    // Reference model: the crossing phase is tracked as elapsed cycles since
    // the grant; lamps and countdown are derived arithmetically from it.
    bit m_s1, m_s2, m_stab, m_stab_d, m_req, m_fault, m_act;
    int m_run, m_t;
    logic [2:0] m_nsp;
    bit e_walk, e_dw, e_abort;
    int e_cd;

    task automatic model_step(input logic r, input logic b, input logic [2:0] n);
        bit rise, legal, gs, grant, ab;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_stab = 0; m_stab_d = 0; m_run = 0;
            m_req = 0; m_fault = 0; m_act = 0; m_t = 0; m_nsp = 3'b100;
            e_abort = 0;
        end else begin
            rise = m_stab && !m_stab_d;
            m_stab_d = m_stab;
            if (m_s2 != m_stab) begin
                m_run++;
                if (m_run == int'(DEB)) begin
                    m_stab = m_s2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = b;
            legal = (n == 3'd1) || (n == 3'd2) || (n == 3'd4);
            gs    = (n == 3'd1) && (m_nsp != 3'd1);
            ab    = m_act && (n != 3'd1);
            grant = 0;
            if (!legal || ab) begin
                m_act = 0;
            end else if (m_act) begin
                m_t++;
                if (m_t == int'(WALKC + FLSH)) m_act = 0;
            end else if (m_req && gs && !m_fault) begin
                m_act = 1;
                m_t = 0;
                grant = 1;
            end
            if (rise) m_req = 1;
            else if (grant) m_req = 0;
            if (!legal) m_fault = 1;
            m_nsp = n;
            e_abort = ab;
        end
        e_walk = m_act && (m_t < int'(WALKC));
        e_dw   = !m_act || ((m_t >= int'(WALKC)) && ((m_t - int'(WALKC)) % 2 == 0));
        e_cd   = (m_act && m_t >= int'(WALKC)) ? int'(WALKC + FLSH) - m_t : 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick(input logic r, input logic b, input logic [2:0] n);
        reset = r;
        btn   = b;
        NS    = n;
        @(posedge clk);
        cyc++;
        model_step(r, b, n);
        #1;
        chk("walk", 32'(walk), 32'(e_walk));
        chk("dont_walk", 32'(dont_walk), 32'(e_dw));
        chk("countdown", 32'(countdown), 32'(e_cd));
        chk("req_pending", 32'(req_pending), 32'(m_req));
        chk("abort", 32'(abort), 32'(e_abort));
        chk("fault", 32'(fault), 32'(m_fault));
    endtask

    initial begin
        int walkcnt, anywalk;
        logic [5:0] pat;
        logic [2:0] bad [5];
        logic [2:0] ns_r;
        logic b_r;
        int hold, glen;
        bad[0] = 3'b000; bad[1] = 3'b011; bad[2] = 3'b101; bad[3] = 3'b110; bad[4] = 3'b111;

        // Reset state
        for (int unsigned i = 0; i < 3; i++) tick(1, 0, 3'b100);
        chk("rst_walk", 32'(walk), 0);
        chk("rst_dont_walk", 32'(dont_walk), 1);
        chk("rst_countdown", 32'(countdown), 0);
        tick(0, 0, 3'b100);

        // Short pulse rejected
        tick(0, 1, 3'b100);
        tick(0, 1, 3'b100);
        for (int unsigned i = 0; i < 10; i++) tick(0, 0, 3'b100);
        chk("short_pulse_req", 32'(req_pending), 0);

        // Held press: accepted on edge DEB+3
        for (int unsigned k = 1; k <= 7; k++) begin
            tick(0, 1, 3'b100);
            if (k == 6) chk("req_edge6", 32'(req_pending), 0);
            if (k == 7) chk("req_edge7", 32'(req_pending), 1);
        end
        for (int unsigned i = 0; i < 8; i++) tick(0, 0, 3'b100);

        // Full WALK + FLASH at green start
        walkcnt = 0;
        pat = '0;
        for (int unsigned i = 0; i < 20; i++) begin
            tick(0, 0, 3'b001);
            walkcnt += int'(walk);
            if (countdown != '0) pat = {pat[4:0], dont_walk};
        end
        chk("walk_len", 32'(walkcnt), 8);
        chk("flash_pat", 32'(pat), 32'b101010);
        chk("req_after_walk", 32'(req_pending), 0);

        // Press mid-green waits for the next green
        anywalk = 0;
        for (int unsigned i = 0; i < 6; i++) begin tick(0, 1, 3'b001); anywalk += int'(walk); end
        for (int unsigned i = 0; i < 6; i++) begin tick(0, 0, 3'b001); anywalk += int'(walk); end
        chk("no_midgreen_walk", 32'(anywalk), 0);
        chk("req_waits", 32'(req_pending), 1);
        tick(0, 0, 3'b010);
        tick(0, 0, 3'b010);
        for (int unsigned i = 0; i < 3; i++) tick(0, 0, 3'b100);
        tick(0, 0, 3'b001);
        chk("walk_next_green", 32'(walk), 1);

        // Abort: NS leaves green on walk cycle 3
        tick(0, 0, 3'b001);
        tick(0, 0, 3'b010);
        chk("abort_pulse", 32'(abort), 1);
        chk("abort_walk", 32'(walk), 0);
        chk("abort_dw", 32'(dont_walk), 1);
        tick(0, 0, 3'b100);
        chk("abort_once", 32'(abort), 0);

        // Reset mid-WALK
        for (int unsigned i = 0; i < 8; i++) tick(0, 1, 3'b100);
        for (int unsigned i = 0; i < 6; i++) tick(0, 0, 3'b100);
        for (int unsigned i = 0; i < 3; i++) tick(0, 0, 3'b001);
        chk("pre_reset_walk", 32'(walk), 1);
        for (int unsigned i = 0; i < 3; i++) tick(1, 0, 3'b001);
        tick(0, 0, 3'b001);
        chk("post_rst_walk", 32'(walk), 0);
        chk("post_rst_dw", 32'(dont_walk), 1);
        chk("post_rst_req", 32'(req_pending), 0);
        chk("post_rst_cd", 32'(countdown), 0);

        // Illegal code: sticky fault, no grants
        tick(0, 0, 3'b100);
        tick(0, 0, 3'b011);
        chk("fault_set", 32'(fault), 1);
        for (int unsigned i = 0; i < 8; i++) tick(0, 1, 3'b100);
        for (int unsigned i = 0; i < 6; i++) tick(0, 0, 3'b100);
        chk("fault_req_latch", 32'(req_pending), 1);
        anywalk = 0;
        for (int unsigned i = 0; i < 10; i++) begin tick(0, 0, 3'b001); anywalk += int'(walk); end
        chk("fault_no_walk", 32'(anywalk), 0);
        chk("fault_sticky", 32'(fault), 1);
        tick(1, 0, 3'b100);
        tick(1, 0, 3'b100);

        // Randomised traffic cycles with random button activity
        b_r = 0;
        hold = 0;
        for (int unsigned ph = 0; ph < 120; ph++) begin
            for (int unsigned seg = 0; seg < 3; seg++) begin
                if (seg == 0) begin
                    ns_r = 3'b001;
                    glen = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 15)) : 16;
                end else if (seg == 1) begin
                    ns_r = 3'b010;
                    glen = 4;
                end else begin
                    ns_r = 3'b100;
                    glen = int'($urandom_range(2, 10));
                end
                for (int j = 0; j < glen; j++) begin
                    if (hold == 0) begin
                        b_r = ~b_r;
                        hold = int'($urandom_range(1, 12));
                    end
                    hold--;
                    if ($urandom_range(0, 499) == 0)
                        tick(1, b_r, ns_r);
                    else if ($urandom_range(0, 299) == 0)
                        tick(0, b_r, bad[$urandom_range(0, 4)]);
                    else
                        tick(0, b_r, ns_r);
                end
            end
            if (m_fault && $urandom_range(0, 3) == 0) tick(1, 0, 3'b100);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
